// File: rtl/sram_be_rmw_ctrl.sv
// ============================================================================
// Module      : sram_be_rmw_ctrl
// Description : Request front end for a SyncSpRamBeNx64 wrapper. The SRAM
//               macro itself has no byte enables, so this block performs
//               byte-masked writes as a read followed by a merged write.
//               Reads return data with a fixed 1-cycle latency.
//               Optional macro RMW_FULLBYP_EN: a write with all byte enables
//               set goes straight to the SRAM in its accept cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_be_rmw_ctrl #(
  parameter  int DATA_W = 64,
  parameter  int ADDR_W = 8,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              Clk_CI,
  input  logic              Rst_RBI,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [BE_W-1:0]   req_be_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              sram_csel_o,
  output logic              sram_wren_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  output logic [BE_W-1:0]   sram_be_o,
  input  logic [DATA_W-1:0] sram_rdata_i,
  output logic [15:0]       rmw_cnt_o
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_MERGE = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_rd_pend;
  logic [ADDR_W-1:0]   r_addr;
  logic [BE_W-1:0]     r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic [15:0]         r_cnt;

  logic                w_ready;
  logic                w_acc;
  logic                w_full;
  logic                w_acc_rd;
  logic                w_acc_rmw;
  logic                w_acc_byp;
  logic [DATA_W-1:0]   w_merged;

  // Ready is forced low while reset is held so nothing is accepted then.
  assign w_ready = (r_state == S_IDLE) && Rst_RBI;
  assign w_acc   = req_valid_i && w_ready;

`ifdef RMW_FULLBYP_EN
  assign w_full = &req_be_i;
`else
  assign w_full = 1'b0;
`endif

  // Writes with no byte enabled are accepted but fall through every path.
  assign w_acc_rd  = w_acc && !req_we_i;
  assign w_acc_rmw = w_acc && req_we_i && (|req_be_i) && !w_full;
  assign w_acc_byp = w_acc && req_we_i && w_full;

  // Byte lane merge: new data where enabled, old SRAM contents elsewhere.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_merge
    assign w_merged[gi*8 +: 8] = r_be[gi] ? r_wdata[gi*8 +: 8]
                                          : sram_rdata_i[gi*8 +: 8];
  end

  // SRAM strobes are combinational so a read issues in its accept cycle.
  always_comb begin
    sram_csel_o  = 1'b0;
    sram_wren_o  = 1'b0;
    sram_addr_o  = req_addr_i;
    sram_wdata_o = req_wdata_i;
    if (r_state == S_MERGE) begin
      sram_csel_o  = Rst_RBI;
      sram_wren_o  = Rst_RBI;
      sram_addr_o  = r_addr;
      sram_wdata_o = w_merged;
    end else if (w_acc_rd || w_acc_rmw) begin
      sram_csel_o  = 1'b1;
    end else if (w_acc_byp) begin
      sram_csel_o  = 1'b1;
      sram_wren_o  = 1'b1;
    end
  end

  // FSM, write capture, read-pending flag and saturating RMW counter.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_state   <= S_IDLE;
      r_rd_pend <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
    end else begin
      r_rd_pend <= w_acc_rd;
      if (r_state == S_IDLE) begin
        if (w_acc_rmw) begin
          r_addr  <= req_addr_i;
          r_be    <= req_be_i;
          r_wdata <= req_wdata_i;
          r_state <= S_MERGE;
        end
      end else begin
        if (r_cnt != 16'hFFFF) begin
          r_cnt <= r_cnt + 16'd1;
        end
        r_state <= S_IDLE;
      end
    end
  end

  assign req_ready_o = w_ready;
  assign rsp_valid_o = r_rd_pend;
  assign rsp_rdata_o = sram_rdata_i;
  assign sram_be_o   = '1;
  assign rmw_cnt_o   = r_cnt;

endmodule

`default_nettype wire
